// File: rtl/ifu_icache_waysel_s1.sv
// ifu_icache_waysel_s1
//   Tag-compare and way-select stage of the IFU instruction cache (S0 -> S1).
//   Four way tags read in S0 are compared against the ITLB physical tag and
//   parity-checked (even parity over tag + parity bit). The per-way hit vector,
//   the per-way tag error vector and the ITLB status are registered into S1,
//   with flush > stall > load priority. Saturating event counters track
//   qualified multi-hits and tag parity errors, counted on load cycles only.
//
// Optional feature macro: ICACHE_WAYSEL_FORCE_MUTEX_EN
//   Defined: S1 stores only the lowest-index hit way, so the vector seen
//   downstream is one-hot or zero. The raw multi-hit indication is registered
//   separately, so multi_hit_s1 and mhit_cnt still report the raw condition.
//   Undefined: the raw hit vector is stored as is.
//
// Ports:
//   clk              core clock
//   rst_l            asynchronous active-low reset
//   tag_rd_data_s0   4 x {parity, tag[TAG_W-1:0]}, way i at [i*(TAG_W+1) +: TAG_W+1]
//   vld_s0           per-way valid
//   ptag_s0          ITLB physical tag
//   cam_vld_s0       ITLB CAM lookup valid
//   tlb_cam_miss_s0  ITLB CAM miss
//   stall_s1         hold all S1 registers
//   flush_s1         clear S1 contents
//   cnt_clr          synchronous clear of both event counters
//   waysel_buf_s1    registered way-hit vector
//   alltag_err_s1    registered per-way tag parity error
//   tlb_cam_miss_s1  registered ITLB miss
//   cam_vld_s1       registered CAM valid
//   hit_s1           qualified hit
//   way_s1           lowest-index hit way (0 when no hit)
//   multi_hit_s1     qualified multi-way hit
//   mhit_cnt         saturating multi-hit event count
//   perr_cnt         saturating tag parity error event count

module ifu_icache_waysel_s1 #(
  parameter int TAG_W = 28,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_l,
  input  logic [4*(TAG_W+1)-1:0] tag_rd_data_s0,
  input  logic [3:0]             vld_s0,
  input  logic [TAG_W-1:0]       ptag_s0,
  input  logic                   cam_vld_s0,
  input  logic                   tlb_cam_miss_s0,
  input  logic                   stall_s1,
  input  logic                   flush_s1,
  input  logic                   cnt_clr,
  output logic [3:0]             waysel_buf_s1,
  output logic [3:0]             alltag_err_s1,
  output logic                   tlb_cam_miss_s1,
  output logic                   cam_vld_s1,
  output logic                   hit_s1,
  output logic [1:0]             way_s1,
  output logic                   multi_hit_s1,
  output logic [CNT_W-1:0]       mhit_cnt,
  output logic [CNT_W-1:0]       perr_cnt
);

  localparam int SW = TAG_W + 1;

  function automatic logic [2:0] pop4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  function automatic logic [3:0] lowest4(input logic [3:0] v);
    logic [3:0] r;
    r = 4'b0000;
    if      (v[0]) r = 4'b0001;
    else if (v[1]) r = 4'b0010;
    else if (v[2]) r = 4'b0100;
    else if (v[3]) r = 4'b1000;
    return r;
  endfunction

  // ---------------- S0 compare ----------------
  logic [3:0] hit_s0;
  logic [3:0] perr_s0;

  for (genvar g = 0; g < 4; g++) begin : g_way
    // Even parity: the XOR over tag + parity bit must be 0 for a good entry.
    assign perr_s0[g] = vld_s0[g] & (^tag_rd_data_s0[g*SW +: SW]);
    // Parity errors deliberately do not mask the hit; qualification happens in S1.
    assign hit_s0[g]  = vld_s0[g] & (tag_rd_data_s0[g*SW +: TAG_W] == ptag_s0);
  end

  logic multi_raw_s0;
  logic qual_s0;
  logic mhit_evt_s0;
  logic perr_evt_s0;
  logic [3:0] hit_ld_s0;

  assign multi_raw_s0 = (pop4(hit_s0) >= 3'd2);
  assign qual_s0      = cam_vld_s0 & ~tlb_cam_miss_s0 & ~(|perr_s0);
  assign mhit_evt_s0  = qual_s0 & multi_raw_s0;
  assign perr_evt_s0  = cam_vld_s0 & (|perr_s0);

`ifdef ICACHE_WAYSEL_FORCE_MUTEX_EN
  assign hit_ld_s0 = lowest4(hit_s0);
`else
  assign hit_ld_s0 = hit_s0;
`endif

  // ---------------- S1 registers ----------------
  logic       load;
  logic [3:0] waysel_q, waysel_d;
  logic [3:0] err_q,    err_d;
  logic       miss_q,   miss_d;
  logic       camv_q,   camv_d;

  assign load = ~flush_s1 & ~stall_s1;

  always_comb begin
    waysel_d = waysel_q;
    err_d    = err_q;
    miss_d   = miss_q;
    camv_d   = camv_q;
    if (flush_s1) begin
      waysel_d = 4'b0000;
      err_d    = 4'b0000;
      miss_d   = 1'b0;
      camv_d   = 1'b0;
    end else if (!stall_s1) begin
      waysel_d = hit_ld_s0;
      err_d    = perr_s0;
      miss_d   = tlb_cam_miss_s0;
      camv_d   = cam_vld_s0;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      waysel_q <= 4'b0000;
      err_q    <= 4'b0000;
      miss_q   <= 1'b0;
      camv_q   <= 1'b0;
    end else begin
      waysel_q <= waysel_d;
      err_q    <= err_d;
      miss_q   <= miss_d;
      camv_q   <= camv_d;
    end
  end

  // Raw multi-hit indication for S1, independent of what waysel_q holds.
  logic multi_raw_s1;

`ifdef ICACHE_WAYSEL_FORCE_MUTEX_EN
  logic multi_q, multi_d;

  always_comb begin
    multi_d = multi_q;
    if (flush_s1)       multi_d = 1'b0;
    else if (!stall_s1) multi_d = multi_raw_s0;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) multi_q <= 1'b0;
    else        multi_q <= multi_d;
  end

  assign multi_raw_s1 = multi_q;
`else
  assign multi_raw_s1 = (pop4(waysel_q) >= 3'd2);
`endif

  // ---------------- S1 derived outputs ----------------
  logic qual_s1;

  assign qual_s1 = camv_q & ~miss_q & ~(|err_q);

  assign waysel_buf_s1   = waysel_q;
  assign alltag_err_s1   = err_q;
  assign tlb_cam_miss_s1 = miss_q;
  assign cam_vld_s1      = camv_q;
  assign hit_s1          = qual_s1 & (|waysel_q);
  assign multi_hit_s1    = qual_s1 & multi_raw_s1;

  always_comb begin
    way_s1 = 2'd0;
    if      (waysel_q[0]) way_s1 = 2'd0;
    else if (waysel_q[1]) way_s1 = 2'd1;
    else if (waysel_q[2]) way_s1 = 2'd2;
    else if (waysel_q[3]) way_s1 = 2'd3;
  end

  // ---------------- event counters ----------------
  // Incremented from S0 values on load cycles only, so an entry held by a
  // stall is counted once when it finally loads.
  logic [CNT_W-1:0] mhit_cnt_q, mhit_cnt_d;
  logic [CNT_W-1:0] perr_cnt_q, perr_cnt_d;

  always_comb begin
    mhit_cnt_d = mhit_cnt_q;
    perr_cnt_d = perr_cnt_q;
    if (cnt_clr) begin
      mhit_cnt_d = '0;
      perr_cnt_d = '0;
    end else if (load) begin
      if (mhit_evt_s0 && !(&mhit_cnt_q)) mhit_cnt_d = mhit_cnt_q + CNT_W'(1);
      if (perr_evt_s0 && !(&perr_cnt_q)) perr_cnt_d = perr_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      mhit_cnt_q <= '0;
      perr_cnt_q <= '0;
    end else begin
      mhit_cnt_q <= mhit_cnt_d;
      perr_cnt_q <= perr_cnt_d;
    end
  end

  assign mhit_cnt = mhit_cnt_q;
  assign perr_cnt = perr_cnt_q;

endmodule

// File: tb/tb_ifu_icache_waysel_s1.sv
// Directed bench for ifu_icache_waysel_s1. A second instance with CNT_W=2
// shares the stimulus and is used for the counter saturation checks.
module tb_ifu_icache_waysel_s1;

  localparam int TAG_W = 28;
  localparam int SW    = TAG_W + 1;
  localparam logic [TAG_W-1:0] PTAG = 28'h0ABCDEF;

`ifdef ICACHE_WAYSEL_FORCE_MUTEX_EN
  localparam logic [3:0] DUAL_Q = 4'b0001;
  localparam logic [3:0] W12_Q  = 4'b0010;
  localparam logic [3:0] W02_Q  = 4'b0001;
`else
  localparam logic [3:0] DUAL_Q = 4'b1001;
  localparam logic [3:0] W12_Q  = 4'b0110;
  localparam logic [3:0] W02_Q  = 4'b0101;
`endif

  logic                 clk = 1'b0;
  logic                 rst_l = 1'b0;
  logic [4*SW-1:0]      tag_rd_data_s0 = '0;
  logic [3:0]           vld_s0 = '0;
  logic [TAG_W-1:0]     ptag_s0 = PTAG;
  logic                 cam_vld_s0 = 1'b0;
  logic                 tlb_cam_miss_s0 = 1'b0;
  logic                 stall_s1 = 1'b0;
  logic                 flush_s1 = 1'b0;
  logic                 cnt_clr = 1'b0;

  logic [3:0]  waysel_buf_s1, alltag_err_s1;
  logic        tlb_cam_miss_s1, cam_vld_s1, hit_s1, multi_hit_s1;
  logic [1:0]  way_s1;
  logic [7:0]  mhit_cnt, perr_cnt;

  logic [3:0]  w2_waysel, w2_err;
  logic        w2_miss, w2_camv, w2_hit, w2_multi;
  logic [1:0]  w2_way;
  logic [1:0]  w2_mhit, w2_perr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ifu_icache_waysel_s1 #(.TAG_W(TAG_W), .CNT_W(8)) dut (
    .clk(clk), .rst_l(rst_l), .tag_rd_data_s0(tag_rd_data_s0), .vld_s0(vld_s0),
    .ptag_s0(ptag_s0), .cam_vld_s0(cam_vld_s0), .tlb_cam_miss_s0(tlb_cam_miss_s0),
    .stall_s1(stall_s1), .flush_s1(flush_s1), .cnt_clr(cnt_clr),
    .waysel_buf_s1(waysel_buf_s1), .alltag_err_s1(alltag_err_s1),
    .tlb_cam_miss_s1(tlb_cam_miss_s1), .cam_vld_s1(cam_vld_s1), .hit_s1(hit_s1),
    .way_s1(way_s1), .multi_hit_s1(multi_hit_s1), .mhit_cnt(mhit_cnt), .perr_cnt(perr_cnt)
  );

  ifu_icache_waysel_s1 #(.TAG_W(TAG_W), .CNT_W(2)) dut2 (
    .clk(clk), .rst_l(rst_l), .tag_rd_data_s0(tag_rd_data_s0), .vld_s0(vld_s0),
    .ptag_s0(ptag_s0), .cam_vld_s0(cam_vld_s0), .tlb_cam_miss_s0(tlb_cam_miss_s0),
    .stall_s1(stall_s1), .flush_s1(flush_s1), .cnt_clr(cnt_clr),
    .waysel_buf_s1(w2_waysel), .alltag_err_s1(w2_err),
    .tlb_cam_miss_s1(w2_miss), .cam_vld_s1(w2_camv), .hit_s1(w2_hit),
    .way_s1(w2_way), .multi_hit_s1(w2_multi), .mhit_cnt(w2_mhit), .perr_cnt(w2_perr)
  );

  // {waysel, err, miss, camv, hit, way, multi}
  wire [13:0] st = {waysel_buf_s1, alltag_err_s1, tlb_cam_miss_s1, cam_vld_s1,
                    hit_s1, way_s1, multi_hit_s1};

  // Ways in hitm carry PTAG, the others a distinct non-matching tag.
  // Parity is correct (even) unless the way is set in errm.
  task automatic drive(input logic [3:0] vld, input logic [3:0] hitm,
                       input logic [3:0] errm, input logic cam, input logic miss);
    for (int i = 0; i < 4; i++) begin
      logic [TAG_W-1:0] t;
      t = hitm[i] ? PTAG : (PTAG ^ TAG_W'(i + 1));
      tag_rd_data_s0[i*SW +: SW] = {errm[i] ? ~(^t) : (^t), t};
    end
    vld_s0          = vld;
    ptag_s0         = PTAG;
    cam_vld_s0      = cam;
    tlb_cam_miss_s0 = miss;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(4'b1111, 4'b0100, 4'b0000, 1'b1, 1'b0);
    #2;
    total++;
    if (st !== 14'd0) begin bad++; $display("FAIL reset_st got=%b want=%b", st, 14'd0); end
    total++;
    if (mhit_cnt !== 8'd0 || perr_cnt !== 8'd0) begin
      bad++; $display("FAIL reset_cnt got=%0d/%0d want=0/0", mhit_cnt, perr_cnt);
    end
    @(negedge clk);
    rst_l = 1'b1;
    #1;
  endtask

  task automatic test_single_hit();
    logic [13:0] exp;
    drive(4'b1111, 4'b0100, 4'b0000, 1'b1, 1'b0);
    tick();
    exp = {4'b0100, 4'b0000, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0};
    total++;
    if (st !== exp) begin bad++; $display("FAIL single_hit got=%b want=%b", st, exp); end
    total++;
    if (mhit_cnt !== 8'd0 || perr_cnt !== 8'd0) begin
      bad++; $display("FAIL single_cnt got=%0d/%0d want=0/0", mhit_cnt, perr_cnt);
    end
  endtask

  task automatic test_dual_hit();
    logic [13:0] exp;
    drive(4'b1111, 4'b1001, 4'b0000, 1'b1, 1'b0);
    tick();
    exp = {DUAL_Q, 4'b0000, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1};
    total++;
    if (st !== exp) begin bad++; $display("FAIL dual_hit got=%b want=%b", st, exp); end
    total++;
    if (mhit_cnt !== 8'd1) begin bad++; $display("FAIL dual_mhit got=%0d want=1", mhit_cnt); end
  endtask

  task automatic test_parity_err();
    logic [13:0] exp;
    drive(4'b1111, 4'b0010, 4'b0010, 1'b1, 1'b0);
    tick();
    exp = {4'b0010, 4'b0010, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0};
    total++;
    if (st !== exp) begin bad++; $display("FAIL perr_st got=%b want=%b", st, exp); end
    total++;
    if (perr_cnt !== 8'd1 || mhit_cnt !== 8'd1) begin
      bad++; $display("FAIL perr_cnt got=%0d/%0d want=1/1", perr_cnt, mhit_cnt);
    end
  endtask

  task automatic test_stall();
    logic [13:0] exp_single, exp_dual;
    exp_single = {4'b0100, 4'b0000, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0};
    exp_dual   = {DUAL_Q, 4'b0000, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1};
    drive(4'b1111, 4'b0100, 4'b0000, 1'b1, 1'b0);
    tick();
    stall_s1 = 1'b1;
    drive(4'b1111, 4'b1001, 4'b0000, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if (st !== exp_single || mhit_cnt !== 8'd1) begin
        bad++; $display("FAIL stall_hold[%0d] got=%b/%0d want=%b/1", c, st, mhit_cnt, exp_single);
      end
    end
    stall_s1 = 1'b0;
    tick();
    total++;
    if (st !== exp_dual || mhit_cnt !== 8'd2) begin
      bad++; $display("FAIL stall_release got=%b/%0d want=%b/2", st, mhit_cnt, exp_dual);
    end
  endtask

  task automatic test_flush();
    flush_s1 = 1'b1;
    stall_s1 = 1'b1;
    drive(4'b1111, 4'b0100, 4'b0010, 1'b1, 1'b1);
    tick();
    total++;
    if (st !== 14'd0) begin bad++; $display("FAIL flush_stall got=%b want=%b", st, 14'd0); end
    stall_s1 = 1'b0;
    drive(4'b1111, 4'b1001, 4'b0000, 1'b1, 1'b0);
    tick();
    total++;
    if (st !== 14'd0 || mhit_cnt !== 8'd2) begin
      bad++; $display("FAIL flush_nocount got=%b/%0d want=%b/2", st, mhit_cnt, 14'd0);
    end
    flush_s1 = 1'b0;
  endtask

  task automatic test_patterns();
    logic [3:0]  tv[9], th[9], te[9];
    logic        tc[9], tm[9];
    logic [13:0] tx[9];
    tv[0]=4'b1111; th[0]=4'b1000; te[0]=4'b0000; tc[0]=1; tm[0]=0; tx[0]={4'b1000,4'b0000,1'b0,1'b1,1'b1,2'd3,1'b0};
    tv[1]=4'b1111; th[1]=4'b0010; te[1]=4'b0000; tc[1]=1; tm[1]=0; tx[1]={4'b0010,4'b0000,1'b0,1'b1,1'b1,2'd1,1'b0};
    tv[2]=4'b1111; th[2]=4'b0000; te[2]=4'b0000; tc[2]=1; tm[2]=0; tx[2]={4'b0000,4'b0000,1'b0,1'b1,1'b0,2'd0,1'b0};
    tv[3]=4'b1111; th[3]=4'b0100; te[3]=4'b0000; tc[3]=0; tm[3]=0; tx[3]={4'b0100,4'b0000,1'b0,1'b0,1'b0,2'd2,1'b0};
    tv[4]=4'b1111; th[4]=4'b1001; te[4]=4'b0000; tc[4]=1; tm[4]=1; tx[4]={DUAL_Q,4'b0000,1'b1,1'b1,1'b0,2'd0,1'b0};
    tv[5]=4'b0110; th[5]=4'b1111; te[5]=4'b0000; tc[5]=1; tm[5]=0; tx[5]={W12_Q,4'b0000,1'b0,1'b1,1'b1,2'd1,1'b1};
    tv[6]=4'b1111; th[6]=4'b0000; te[6]=4'b1000; tc[6]=0; tm[6]=0; tx[6]={4'b0000,4'b1000,1'b0,1'b0,1'b0,2'd0,1'b0};
    tv[7]=4'b0111; th[7]=4'b0000; te[7]=4'b1000; tc[7]=1; tm[7]=0; tx[7]={4'b0000,4'b0000,1'b0,1'b1,1'b0,2'd0,1'b0};
    tv[8]=4'b1111; th[8]=4'b0101; te[8]=4'b0101; tc[8]=1; tm[8]=0; tx[8]={W02_Q,4'b0101,1'b0,1'b1,1'b0,2'd0,1'b0};
    for (int k = 0; k < 9; k++) begin
      drive(tv[k], th[k], te[k], tc[k], tm[k]);
      tick();
      total++;
      if (st !== tx[k]) begin bad++; $display("FAIL pattern[%0d] got=%b want=%b", k, st, tx[k]); end
    end
    total++;
    if (mhit_cnt !== 8'd3 || perr_cnt !== 8'd2) begin
      bad++; $display("FAIL pattern_cnt got=%0d/%0d want=3/2", mhit_cnt, perr_cnt);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp2;
    cnt_clr = 1'b1;
    drive(4'b1111, 4'b1001, 4'b0000, 1'b1, 1'b0);
    tick();
    cnt_clr = 1'b0;
    total++;
    if (mhit_cnt !== 8'd0 || w2_mhit !== 2'd0 || perr_cnt !== 8'd0) begin
      bad++; $display("FAIL clr_first got=%0d/%0d/%0d want=0/0/0", mhit_cnt, w2_mhit, perr_cnt);
    end
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp2 = (k < 3) ? 2'(k) : 2'd3;
      total++;
      if (w2_mhit !== exp2 || mhit_cnt !== 8'(k)) begin
        bad++; $display("FAIL mhit_sat[%0d] got=%0d/%0d want=%0d/%0d", k, w2_mhit, mhit_cnt, exp2, k);
      end
    end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    total++;
    if (w2_mhit !== 2'd0 || mhit_cnt !== 8'd0) begin
      bad++; $display("FAIL clr_beats_inc got=%0d/%0d want=0/0", w2_mhit, mhit_cnt);
    end
    drive(4'b1111, 4'b0000, 4'b0010, 1'b1, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      exp2 = (k < 3) ? 2'(k) : 2'd3;
      total++;
      if (w2_perr !== exp2 || perr_cnt !== 8'(k)) begin
        bad++; $display("FAIL perr_sat[%0d] got=%0d/%0d want=%0d/%0d", k, w2_perr, perr_cnt, exp2, k);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [13:0] exp;
    drive(4'b1111, 4'b1001, 4'b0000, 1'b1, 1'b0);
    tick();
    stall_s1 = 1'b1;
    #3;
    rst_l = 1'b0;
    #1;
    total++;
    if (st !== 14'd0 || mhit_cnt !== 8'd0 || perr_cnt !== 8'd0 || w2_mhit !== 2'd0) begin
      bad++; $display("FAIL async_rst got=%b/%0d/%0d want=0/0/0", st, mhit_cnt, perr_cnt);
    end
    @(negedge clk);
    rst_l    = 1'b1;
    stall_s1 = 1'b0;
    drive(4'b1111, 4'b0100, 4'b0000, 1'b1, 1'b0);
    tick();
    exp = {4'b0100, 4'b0000, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0};
    total++;
    if (st !== exp || mhit_cnt !== 8'd0) begin
      bad++; $display("FAIL post_rst_load got=%b/%0d want=%b/0", st, mhit_cnt, exp);
    end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_dual_hit();
    test_parity_err();
    test_stall();
    test_flush();
    test_patterns();
    test_saturation();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ifu_icache_waysel_s1.md
Name: ifu_icache_waysel_s1

Overview:
- S0→S1 tag-compare and way-select stage of the IFU instruction cache.
- Compares four way tags read in S0 against the ITLB physical tag and checks tag parity.
- Registers the per-way hit vector, per-way tag error vector and ITLB status into S1, with stall and flush.
- Produces the S1 signals consumed by the icache mutex monitor and the fetch datapath, plus saturating event counters for multi-hit and tag-parity errors.

Parameters:
- TAG_W, 28: physical tag width per way, excluding the parity bit.
- CNT_W, 8: width of each saturating event counter.

Ports:
- clk  in  1  core clock; all state updates on posedge.
- rst_l  in  1  reset; asynchronous assert, active-low.
- tag_rd_data_s0  in  4*(TAG_W+1)  way i occupies bits [i*(TAG_W+1) +: TAG_W+1]; the MSB of each slice is the parity bit.
- vld_s0  in  4  per-way valid bit.
- ptag_s0  in  TAG_W  ITLB physical tag.
- cam_vld_s0  in  1  ITLB CAM lookup valid.
- tlb_cam_miss_s0  in  1  ITLB CAM miss.
- stall_s1  in  1  hold all S1 registers.
- flush_s1  in  1  kill S1 contents.
- cnt_clr  in  1  synchronous clear of both counters.
- waysel_buf_s1  out  4  registered way-hit vector.
- alltag_err_s1  out  4  registered per-way tag parity error.
- tlb_cam_miss_s1  out  1  registered ITLB miss.
- cam_vld_s1  out  1  registered CAM valid.
- hit_s1  out  1  qualified icache hit.
- way_s1  out  2  encoded hit way (lowest index).
- multi_hit_s1  out  1  qualified non-mutex hit.
- mhit_cnt  out  CNT_W  multi-hit event count.
- perr_cnt  out  CNT_W  tag parity error event count.

Behaviour:
- Reset (rst_l=0, asynchronous): every S1 register and both counters go to 0. Consequently all outputs are 0.
- S0 combinational, per way i:
  - perr_i = vld_s0[i] & (XOR of all TAG_W+1 bits of slice i), i.e. even parity.
  - hit_i = vld_s0[i] & (slice i tag bits == ptag_s0).
  - A parity error does not mask hit_i.
- S1 register update priority per cycle: flush > stall > load.
  - flush_s1=1: waysel_buf_s1, alltag_err_s1, cam_vld_s1 and tlb_cam_miss_s1 all cleared to 0 next edge, regardless of stall.
  - stall_s1=1 (no flush): all S1 registers hold.
  - Otherwise: load S0 values. Latency from S0 inputs to S1 outputs is 1 cycle.
- Derived S1 outputs (combinational from S1 registers), with q = cam_vld_s1 & ~tlb_cam_miss_s1 & ~|alltag_err_s1:
  - hit_s1 = q & |waysel_buf_s1.
  - multi_hit_s1 = q & (popcount(waysel_buf_s1) >= 2).
  - way_s1 = index of lowest set bit of waysel_buf_s1; 0 when the vector is 0.
- Counters are evaluated on load cycles only (no flush, no stall), using S0 values, so a stalled S1 entry is never counted twice.
  - mhit_cnt += 1 when the S0 equivalent of multi_hit_s1 is true.
  - perr_cnt += 1 when cam_vld_s0 & |perr.
  - Both counters saturate at 2^CNT_W-1.
  - cnt_clr=1 clears both counters next edge; clear beats a simultaneous increment, giving 0.
- Reset asserted mid-stall or mid-flush: immediate clear; the first load after rst_l rises behaves normally.
- ptag_s0 and the tag inputs are don't-care when cam_vld_s0=0. Their hit and error values still load, but q=0 blocks hit_s1 and multi_hit_s1.

Optional Feature:
- Macro: ICACHE_WAYSEL_FORCE_MUTEX_EN.
- Defined: on load, waysel_buf_s1 stores only the lowest-index set bit of the raw hit vector, so downstream always sees a one-hot or zero vector. Raw popcount is registered separately, so multi_hit_s1 and mhit_cnt still reflect the raw multi-hit.
- Undefined: the raw hit vector is stored unmodified.

Test Plan:
- Reset then single hit: vld=4'b1111, way2 tag == ptag=28'h0ABCDEF, good parity, cam_vld=1, miss=0 → next cycle waysel_buf_s1=4'b0100, hit_s1=1, way_s1=2, multi_hit_s1=0, counters 0.
- Dual hit on ways 0 and 3 → waysel_buf_s1=4'b1001 (4'b0001 with macro), multi_hit_s1=1, way_s1=0, mhit_cnt=1.
- Way1 with flipped parity bit, valid, plus hit on way1 → alltag_err_s1=4'b0010, hit_s1=0, multi_hit_s1=0, perr_cnt=1.
- Stall for 3 cycles while S0 presents a new dual-hit → S1 outputs unchanged, mhit_cnt unchanged. On release, S1 updates and mhit_cnt increments by exactly 1.
- flush_s1=1 together with stall_s1=1 → next cycle cam_vld_s1=0 and waysel_buf_s1=0.
- CNT_W=2: 5 consecutive dual-hit loads → mhit_cnt=3 (saturated). Then cnt_clr=1 alongside a dual-hit load → mhit_cnt=0. Async rst_l pulse mid-cycle → all outputs 0 before the next edge.
